sec_lock_pipe: RTL and testbench

Pipelined, parametrised single-error-correcting (Hamming SEC) data corrector with a serial key-unlock state machine. It is the sequential, width-generic successor to our locked combinational 32-bit SEC circuits. A valid/ready stream of data words plus check bits enters, and corrected words with status flags leave two stages later. Correction is active only while the unit is unlocked by the correct serially loaded key; while locked, data passes through raw.

---
 rtl/sec_lock_pipe.sv | 185 ++++++++++++++++++
 tb/tb_sec_lock_pipe.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sec_lock_pipe.sv
// Two-stage Hamming SEC corrector gated by a serial key-unlock FSM.
// Correction applies only to words that enter stage 2 while the unit is unlocked.
module sec_lock_pipe #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       CHK_W     = 6,
  parameter int unsigned       KEY_W     = 16,
  parameter logic [KEY_W-1:0]  KEY_VALUE = 16'hA5C3,
  parameter int unsigned       FAIL_CYC  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CHK_W-1:0]  in_chk,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_corr,
  output logic              out_uncorr,
  input  logic              key_start,
  input  logic              key_valid,
  input  logic              key_bit,
  output logic              unlocked,
  output logic              key_fail
);

  localparam int unsigned KCNT_W = $clog2(KEY_W + 1);
  localparam int unsigned FCNT_W = $clog2(FAIL_CYC + 1);

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_LOADING  = 2'd1,
    ST_UNLOCKED = 2'd2,
    ST_FAIL     = 2'd3
  } state_t;

  state_t              state;
  logic [KEY_W-1:0]    shreg;
  logic [KEY_W-1:0]    shifted;
  logic [KCNT_W-1:0]   kcnt;
  logic [FCNT_W-1:0]   fcnt;

  logic                s1_valid;
  logic [DATA_W-1:0]   s1_data;
  logic [CHK_W-1:0]    s1_syn;
  logic                s2_valid;
  logic                s1_adv;
  logic                s2_adv;

  logic [CHK_W-1:0]    calc_chk;
  logic [DATA_W-1:0]   fix_data;
  logic                hit_col;
  logic                syn_pow2;
  logic                fix_corr;
  logic                fix_uncorr;

  // Column of data bit idx: the (idx+1)-th integer >= 3 that is not a power of two.
  function automatic logic [CHK_W-1:0] col_of(input int unsigned idx);
    int unsigned cnt;
    col_of = '0;
    cnt    = 0;
    for (int unsigned v = 3; v < (32'd1 << CHK_W); v++) begin
      if ((v & (v - 1)) != 0) begin
        if (cnt == idx) col_of = v[CHK_W-1:0];
        cnt = cnt + 1;
      end
    end
  endfunction

  always_comb begin
    calc_chk = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (in_data[i]) calc_chk = calc_chk ^ col_of(i);
    end
  end

  always_comb begin
    fix_data = s1_data;
    hit_col  = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (s1_syn == col_of(i)) begin
        fix_data[i] = ~s1_data[i];
        hit_col     = 1'b1;
      end
    end
    syn_pow2   = (s1_syn != '0) && ((s1_syn & (s1_syn - CHK_W'(1))) == '0);
    fix_corr   = syn_pow2 | hit_col;
    fix_uncorr = (s1_syn != '0) && !fix_corr;
  end

  assign s2_adv    = !s2_valid | out_ready;
  assign s1_adv    = !s1_valid | s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_syn   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_syn  <= in_chk ^ calc_chk;
      end
    end
  end

  // Lock state is taken from the current register, so a word moving into
  // stage 2 on the unlocking edge is still handled as locked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      out_data   <= '0;
      out_corr   <= 1'b0;
      out_uncorr <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        if (state == ST_UNLOCKED) begin
          out_data   <= fix_data;
          out_corr   <= fix_corr;
          out_uncorr <= fix_uncorr;
        end else begin
          out_data   <= s1_data;
          out_corr   <= 1'b0;
          out_uncorr <= 1'b0;
        end
      end
    end
  end

  assign shifted = {shreg[KEY_W-2:0], key_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_LOCKED;
      shreg <= '0;
      kcnt  <= '0;
      fcnt  <= '0;
    end else begin
      case (state)
        ST_LOCKED, ST_UNLOCKED: begin
          if (key_start) begin
            state <= ST_LOADING;
            shreg <= '0;
            kcnt  <= '0;
          end
        end
        ST_LOADING: begin
          if (key_start) begin
            shreg <= '0;
            kcnt  <= '0;
          end else if (key_valid) begin
            shreg <= shifted;
            kcnt  <= kcnt + KCNT_W'(1);
            if (kcnt == KCNT_W'(KEY_W - 1)) begin
              if (shifted == KEY_VALUE) begin
                state <= ST_UNLOCKED;
              end else begin
                state <= ST_FAIL;
                fcnt  <= FCNT_W'(FAIL_CYC);
              end
            end
          end
        end
        ST_FAIL: begin
          if (fcnt <= FCNT_W'(1)) begin
            state <= ST_LOCKED;
            fcnt  <= '0;
          end else begin
            fcnt <= fcnt - FCNT_W'(1);
          end
        end
        default: state <= ST_LOCKED;
      endcase
    end
  end

  assign unlocked = (state == ST_UNLOCKED);
  assign key_fail = (state == ST_FAIL);

endmodule

// File: tb/tb_sec_lock_pipe.sv
// Randomized and directed bench for sec_lock_pipe against a queue-based reference model.
module tb_sec_lock_pipe;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 6;
  localparam int unsigned KW = 16;
  localparam int unsigned FC = 8;
  localparam logic [15:0] KEY_OK  = 16'hA5C3;
  localparam logic [15:0] KEY_BAD = 16'hA5C2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_chk = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_corr;
  logic          out_uncorr;
  logic          key_start = 1'b0;
  logic          key_valid = 1'b0;
  logic          key_bit = 1'b0;
  logic          unlocked;
  logic          key_fail;

  sec_lock_pipe #(
    .DATA_W(DW), .CHK_W(CW), .KEY_W(KW), .KEY_VALUE(KEY_OK), .FAIL_CYC(FC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_chk(in_chk),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_corr(out_corr), .out_uncorr(out_uncorr),
    .key_start(key_start), .key_valid(key_valid), .key_bit(key_bit),
    .unlocked(unlocked), .key_fail(key_fail)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [CW-1:0] cols [DW];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] enc(input logic [DW-1:0] d);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < int'(DW); i++) if (d[i]) c = c ^ cols[i];
    return c;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Bits from..to-1 of k, counted from the MSB.
  task automatic key_send(input logic [15:0] k, input int from, input int to);
    for (int i = from; i < to; i++) begin
      key_valid = 1'b1;
      key_bit   = k[15-i];
      cyc();
    end
    key_valid = 1'b0;
  endtask

  task automatic key_begin();
    key_start = 1'b1;
    cyc();
    key_start = 1'b0;
  endtask

  task automatic send_word(input string tag, input logic [DW-1:0] d, input logic [CW-1:0] c,
                           input logic [DW-1:0] ed, input logic ec, input logic eu);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    in_chk    = c;
    #1;
    check({tag, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_lat1"}, out_valid, 1'b0);
    cyc();
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_data"}, out_data, ed);
    check({tag, "_corr"}, out_corr, ec);
    check({tag, "_uncorr"}, out_uncorr, eu);
    cyc();
  endtask

  initial begin
    logic [DW-1:0] q_d[$];
    logic [DW-1:0] d, wd, hold_d;
    logic [CW-1:0] wc;
    int unsigned   sent, got, inflight, fcount, r;
    logic          pend, hold;

    begin
      int unsigned k;
      k = 0;
      for (int unsigned v = 3; k < DW; v++) begin
        if ((v & (v - 1)) != 0) begin
          cols[k] = v[CW-1:0];
          k++;
        end
      end
    end

    #2 rst_n = 1'b0;
    cyc(); cyc();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_flags", {out_corr, out_uncorr}, 2'b00);
    check("rst_unlocked", unlocked, 1'b0);
    check("rst_key_fail", key_fail, 1'b0);
    rst_n = 1'b1;
    cyc();

    send_word("lock_pass", 32'h1, 6'h0, 32'h1, 1'b0, 1'b0);
    send_word("lock_raw3f", 32'h0, 6'h3F, 32'h0, 1'b0, 1'b0);

    key_begin();
    key_send(KEY_OK, 0, 15);
    check("unlock_early", unlocked, 1'b0);
    key_send(KEY_OK, 15, 16);
    check("unlock", unlocked, 1'b1);
    send_word("corr_d0", 32'h1, 6'h0, 32'h0, 1'b1, 1'b0);
    send_word("corr_chk", 32'h0, 6'h04, 32'h0, 1'b1, 1'b0);
    send_word("uncorr", 32'h0, 6'h3F, 32'h0, 1'b0, 1'b1);

    key_begin();
    check("relock", unlocked, 1'b0);
    key_send(KEY_OK, 0, 5);
    key_start = 1'b1;
    key_valid = 1'b1;
    key_bit   = 1'b1;
    cyc();
    key_start = 1'b0;
    key_valid = 1'b0;
    key_send(KEY_OK, 0, 11);
    check("restart_cnt_fail", key_fail, 1'b0);
    check("restart_cnt_unl", unlocked, 1'b0);
    key_send(KEY_OK, 11, 16);
    check("restart_unlock", unlocked, 1'b1);

    // Word reaches stage 2 on the same edge that unlocks: stays raw.
    key_begin();
    key_send(KEY_OK, 0, 14);
    key_valid = 1'b1;
    key_bit   = KEY_OK[1];
    in_valid  = 1'b1;
    in_data   = 32'h1;
    in_chk    = 6'h0;
    cyc();
    in_valid  = 1'b0;
    key_bit   = KEY_OK[0];
    cyc();
    key_valid = 1'b0;
    check("edge_unlocked", unlocked, 1'b1);
    check("edge_valid", out_valid, 1'b1);
    check("edge_data", out_data, 32'h1);
    check("edge_corr", out_corr, 1'b0);
    cyc();

    sent = 0; got = 0; inflight = 0; pend = 1'b0; hold = 1'b0; hold_d = '0;
    wd = '0; wc = '0; d = '0;
    for (int cy = 0; cy < 600 && got < 20; cy++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (!pend && sent < 20 && $urandom_range(0, 3) != 0) begin
        d  = $urandom;
        wd = d;
        wc = enc(d);
        r  = $urandom_range(0, DW + CW - 1);
        if (r < DW) wd[r] = ~wd[r];
        else        wc[r-DW] = ~wc[r-DW];
        pend = 1'b1;
      end
      in_valid = pend;
      in_data  = wd;
      in_chk   = wc;
      #2;
      check("bp_in_ready", in_ready, !(inflight == 2 && !out_ready));
      if (hold) check("bp_hold", out_data, hold_d);
      if (in_valid && in_ready) begin
        q_d.push_back(d);
        sent++;
        inflight++;
        pend = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (q_d.size() == 0) begin
          check("bp_extra", 1'b1, 1'b0);
        end else begin
          check("bp_data", out_data, q_d.pop_front());
          check("bp_flags", {out_corr, out_uncorr}, 2'b10);
          inflight--;
        end
        got++;
      end
      hold   = out_valid && !out_ready;
      hold_d = out_data;
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_done", got, 20);
    for (int i = 0; i < 3; i++) begin
      check("bp_drained", out_valid, 1'b0);
      cyc();
    end

    key_begin();
    key_send(KEY_BAD, 0, 16);
    check("bad_unlocked", unlocked, 1'b0);
    fcount = 0;
    for (int i = 0; i < 20; i++) begin
      if (key_fail) fcount++;
      key_start = (i == 3);
      cyc();
    end
    key_start = 1'b0;
    check("fail_len", fcount, FC);
    check("fail_locked", {unlocked, key_fail}, 2'b00);
    send_word("fail_raw", 32'h1, 6'h0, 32'h1, 1'b0, 1'b0);

    key_begin();
    key_send(KEY_OK, 0, 16);
    check("reunlock", unlocked, 1'b1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h5;
    in_chk    = 6'h0;
    cyc();
    in_data   = 32'h6;
    cyc();
    in_valid  = 1'b0;
    check("mid_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_async", out_valid, 1'b0);
    check("mid_lock", unlocked, 1'b0);
    cyc();
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    cyc();
    for (int i = 0; i < 4; i++) begin
      check("mid_stale", out_valid, 1'b0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
